// File: rtl/pwm_multi_pkg.sv
// Shared constants for the multi-channel PWM peripheral: register word
// addresses and the bit positions inside the CTRL register.
package pwm_multi_pkg;

    localparam int ADDR_CTRL   = 0;
    localparam int ADDR_PRESC  = 1;
    localparam int ADDR_PERIOD = 2;
    localparam int ADDR_STATUS = 3;
    localparam int ADDR_DUTY0  = 4;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_POL0   = 2;

endpackage

// File: rtl/pwm_multi_ch.sv
// One PWM channel: active duty copy that reloads from the bus register on a
// shadow-load pulse, plus the registered compare-and-polarity output.
module pwm_multi_ch #(
    parameter int CNT_W = 16
) (
    input  logic             iClk,
    input  logic             iReset_n,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] duty_bus,
    input  logic [CNT_W-1:0] cnt,
    input  logic             pol,
    output logic             pwm
);

    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic             pwm_q, pwm_d;

    // While disabled the compare term is forced off so the pin rests at pol.
    always_comb begin
        duty_act_d = load ? duty_bus : duty_act_q;
        pwm_d      = (en && (cnt < duty_act_q)) ^ pol;
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            duty_act_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            duty_act_q <= duty_act_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/pwm_multi_ctrl.sv
// Bus-mapped multi-channel PWM: register file, shared prescaler and period
// counter, wrap/IRQ status, and NUM_CH shadowed compare channels.
module pwm_multi_ctrl
    import pwm_multi_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 8,
    parameter int ADDR_W  = 4
) (
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic              iChipselect_n,
    input  logic              iWrite_n,
    input  logic              iRead_n,
    input  logic [ADDR_W-1:0] iAddress,
    input  logic [31:0]       iData,
    output logic [31:0]       oData,
    output logic              oIrq,
    output logic [NUM_CH-1:0] oPwm
);

    logic                          wr_en, rd_en;
    logic                          en, irq_en;
    logic [NUM_CH-1:0]             pol;
    logic                          tick, wrap_evt, shadow_load;

    logic [NUM_CH+1:0]             ctrl_q, ctrl_d;
    logic [PRESC_W-1:0]            presc_q, presc_d;
    logic [CNT_W-1:0]              period_q, period_d;
    logic                          wrap_q, wrap_d;
    logic [NUM_CH-1:0][CNT_W-1:0]  duty_q, duty_d;
    logic [PRESC_W-1:0]            presc_cnt_q, presc_cnt_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [CNT_W-1:0]              period_act_q, period_act_d;
    logic [31:0]                   rdata_q, rdata_d;

    // Registers narrower than the bus ignore the upper data bits.
    logic unused_data;
    assign unused_data = ^iData;

    assign wr_en  = !iChipselect_n && !iWrite_n;
    assign rd_en  = !iChipselect_n && !iRead_n && iWrite_n;
    assign en     = ctrl_q[CTRL_EN];
    assign irq_en = ctrl_q[CTRL_IRQ_EN];
    assign pol    = ctrl_q[CTRL_POL0 +: NUM_CH];

    // Prescaler and period counter; both rest at zero while disabled.
    always_comb begin
        tick         = en && (presc_cnt_q >= presc_q);
        wrap_evt     = tick && (cnt_q == period_act_q);
        shadow_load  = !en || wrap_evt;
        presc_cnt_d  = (!en || tick) ? '0 : presc_cnt_q + PRESC_W'(1);
        cnt_d        = cnt_q;
        if (!en || wrap_evt)
            cnt_d = '0;
        else if (tick)
            cnt_d = cnt_q + CNT_W'(1);
        period_act_d = shadow_load ? period_q : period_act_q;
    end

    // A wrap on the same edge as a clear-write keeps the flag set.
    always_comb begin
        ctrl_d   = ctrl_q;
        presc_d  = presc_q;
        period_d = period_q;
        duty_d   = duty_q;
        wrap_d   = wrap_q;
        if (wr_en) begin
            if (iAddress == ADDR_W'(ADDR_CTRL))
                ctrl_d = iData[NUM_CH+1:0];
            if (iAddress == ADDR_W'(ADDR_PRESC))
                presc_d = iData[PRESC_W-1:0];
            if (iAddress == ADDR_W'(ADDR_PERIOD))
                period_d = iData[CNT_W-1:0];
            if (iAddress == ADDR_W'(ADDR_STATUS) && iData[0])
                wrap_d = 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                if (iAddress == ADDR_W'(ADDR_DUTY0 + k))
                    duty_d[k] = iData[CNT_W-1:0];
            end
        end
        if (wrap_evt)
            wrap_d = 1'b1;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = '0;
            if (iAddress == ADDR_W'(ADDR_CTRL))
                rdata_d[NUM_CH+1:0] = ctrl_q;
            if (iAddress == ADDR_W'(ADDR_PRESC))
                rdata_d[PRESC_W-1:0] = presc_q;
            if (iAddress == ADDR_W'(ADDR_PERIOD))
                rdata_d[CNT_W-1:0] = period_q;
            if (iAddress == ADDR_W'(ADDR_STATUS))
                rdata_d[0] = wrap_q;
            for (int k = 0; k < NUM_CH; k++) begin
                if (iAddress == ADDR_W'(ADDR_DUTY0 + k))
                    rdata_d[CNT_W-1:0] = duty_q[k];
            end
        end
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            ctrl_q       <= '0;
            presc_q      <= '0;
            period_q     <= '0;
            wrap_q       <= 1'b0;
            duty_q       <= '0;
            presc_cnt_q  <= '0;
            cnt_q        <= '0;
            period_act_q <= '0;
            rdata_q      <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            presc_q      <= presc_d;
            period_q     <= period_d;
            wrap_q       <= wrap_d;
            duty_q       <= duty_d;
            presc_cnt_q  <= presc_cnt_d;
            cnt_q        <= cnt_d;
            period_act_q <= period_act_d;
            rdata_q      <= rdata_d;
        end
    end

    assign oData = rdata_q;
    assign oIrq  = wrap_q && irq_en;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        pwm_multi_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .iClk     (iClk),
            .iReset_n (iReset_n),
            .en       (en),
            .load     (shadow_load),
            .duty_bus (duty_q[k]),
            .cnt      (cnt_q),
            .pol      (pol[k]),
            .pwm      (oPwm[k])
        );
    end

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Directed bench for pwm_multi_ctrl: reset state, duty waveforms, shadowed
// duty updates, 0%/100% duty and polarity, IRQ/wrap clearing, disable and reset.
module tb_pwm_multi_ctrl;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 16;
    localparam int PRESC_W = 8;
    localparam int ADDR_W  = 4;

    logic              iClk;
    logic              iReset_n;
    logic              iChipselect_n;
    logic              iWrite_n;
    logic              iRead_n;
    logic [ADDR_W-1:0] iAddress;
    logic [31:0]       iData;
    logic [31:0]       oData;
    logic              oIrq;
    logic [NUM_CH-1:0] oPwm;

    int          checks = 0;
    int          errors = 0;
    int          k      = 0;
    logic [31:0] rdata;

    pwm_multi_ctrl #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .iClk          (iClk),
        .iReset_n      (iReset_n),
        .iChipselect_n (iChipselect_n),
        .iWrite_n      (iWrite_n),
        .iRead_n       (iRead_n),
        .iAddress      (iAddress),
        .iData         (iData),
        .oData         (oData),
        .oIrq          (oIrq),
        .oPwm          (oPwm)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // k counts rising edges since the last enable; every task returns on a falling edge.
    task automatic step();
        @(negedge iClk);
        k++;
    endtask

    task automatic bus_write(input int addr, input logic [31:0] data);
        iAddress      = ADDR_W'(addr);
        iData         = data;
        iChipselect_n = 1'b0;
        iWrite_n      = 1'b0;
        @(negedge iClk);
        k++;
        iChipselect_n = 1'b1;
        iWrite_n      = 1'b1;
    endtask

    task automatic bus_read(input int addr, output logic [31:0] data);
        iAddress      = ADDR_W'(addr);
        iChipselect_n = 1'b0;
        iRead_n       = 1'b0;
        @(negedge iClk);
        k++;
        iChipselect_n = 1'b1;
        iRead_n       = 1'b1;
        data          = oData;
    endtask

    // Period of 10 clocks: the output seen after edge n reflects counter value (n-1) mod 10.
    function automatic logic pwm_on(input int n, input int duty);
        return ((n - 1) % 10) < duty;
    endfunction

    initial begin
        iReset_n      = 1'b0;
        iChipselect_n = 1'b1;
        iWrite_n      = 1'b1;
        iRead_n       = 1'b1;
        iAddress      = '0;
        iData         = '0;
        $display("[TB] start");

        // Reset state and every address reading back zero
        repeat (2) @(negedge iClk);
        check_output("rst_pwm", 32'(oPwm), 32'h0);
        iReset_n = 1'b1;
        @(negedge iClk);
        check_output("rst_irq", 32'(oIrq), 32'h0);
        check_output("rst_odata", oData, 32'h0);
        for (int a = 0; a < 16; a++) begin
            bus_read(a, rdata);
            check_output($sformatf("rst_read%0d", a), rdata, 32'h0);
        end

        // PRESC=0, PERIOD=9, DUTY0=3: 3 high, 7 low
        bus_write(2, 32'd9);
        bus_write(4, 32'd3);
        bus_write(1, 32'd0);
        bus_write(0, 32'h1);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            check_output($sformatf("duty3_k%0d", k), 32'(oPwm), {31'b0, pwm_on(k, 3)});
        end

        // DUTY0 3->7 mid-period applies only from the wrap at edge 30
        repeat (4) step();
        bus_write(4, 32'd7);
        check_output($sformatf("shadow_k%0d", k), 32'(oPwm), {31'b0, pwm_on(k, 3)});
        while (k < 40) begin
            step();
            check_output($sformatf("shadow_k%0d", k), 32'(oPwm),
                         {31'b0, pwm_on(k, (k >= 31) ? 7 : 3)});
        end

        // DUTY1=0 stays low, DUTY2=20 > PERIOD goes solid high after the wrap at edge 50
        bus_write(5, 32'd0);
        bus_write(6, 32'd20);
        while (k < 60) begin
            step();
            if (k >= 43)
                check_output($sformatf("dutyedge_k%0d", k), 32'(oPwm),
                             {28'b0, 1'b0, (k >= 51), 1'b0, pwm_on(k, 7)});
        end

        // pol[1]=1 inverts the constant-low channel
        bus_write(0, 32'h9);
        check_output($sformatf("pol_k%0d", k), 32'(oPwm), {28'b0, 1'b0, 1'b1, 1'b0, pwm_on(k, 7)});
        while (k < 70) begin
            step();
            check_output($sformatf("pol_k%0d", k), 32'(oPwm),
                         {28'b0, 1'b0, 1'b1, (k >= 62), pwm_on(k, 7)});
        end

        // IRQ: PRESC=3, PERIOD=4 -> wrap every 20 clocks
        bus_write(0, 32'h0);
        bus_write(1, 32'd3);
        bus_write(2, 32'd4);
        bus_write(3, 32'h1);
        check_output("dis_pwm", 32'(oPwm), 32'h0);
        bus_read(3, rdata);
        check_output("status_clr", rdata, 32'h0);
        bus_write(0, 32'h3);
        k = 0;
        repeat (19) step();
        check_output("irq_k19", 32'(oIrq), 32'h0);
        step();
        check_output("irq_k20", 32'(oIrq), 32'h1);
        bus_write(3, 32'h1);
        check_output("irq_cleared", 32'(oIrq), 32'h0);
        bus_read(3, rdata);
        check_output("status_after_clr", rdata, 32'h0);
        while (k < 39) step();
        check_output("irq_k39", 32'(oIrq), 32'h0);
        bus_write(3, 32'h1);
        check_output("irq_wrap_wins", 32'(oIrq), 32'h1);
        bus_read(3, rdata);
        check_output("status_wrap_wins", rdata, 32'h1);

        // Disable mid-period: outputs rest at pol, registers kept
        bus_write(0, 32'h17);
        repeat (5) step();
        bus_write(0, 32'h16);
        step();
        check_output("dis_pol", 32'(oPwm), 32'h5);
        step();
        check_output("dis_pol_hold", 32'(oPwm), 32'h5);
        check_output("dis_irq", 32'(oIrq), 32'h1);
        bus_read(0, rdata);
        check_output("keep_ctrl", rdata, 32'h16);
        bus_read(1, rdata);
        check_output("keep_presc", rdata, 32'd3);
        bus_read(2, rdata);
        check_output("keep_period", rdata, 32'd4);
        bus_read(4, rdata);
        check_output("keep_duty0", rdata, 32'd7);
        bus_read(6, rdata);
        check_output("keep_duty2", rdata, 32'd20);

        // Asynchronous reset mid-period clears everything at once
        bus_write(0, 32'h17);
        repeat (6) step();
        #2 iReset_n = 1'b0;
        #1;
        check_output("arst_pwm", 32'(oPwm), 32'h0);
        check_output("arst_irq", 32'(oIrq), 32'h0);
        check_output("arst_odata", oData, 32'h0);
        @(negedge iClk);
        iReset_n = 1'b1;
        bus_read(0, rdata);
        check_output("arst_ctrl", rdata, 32'h0);
        bus_read(1, rdata);
        check_output("arst_presc", rdata, 32'h0);
        bus_read(2, rdata);
        check_output("arst_period", rdata, 32'h0);
        bus_read(3, rdata);
        check_output("arst_status", rdata, 32'h0);
        bus_read(4, rdata);
        check_output("arst_duty0", rdata, 32'h0);
        bus_read(6, rdata);
        check_output("arst_duty2", rdata, 32'h0);
        repeat (3) step();
        check_output("arst_pwm_idle", 32'(oPwm), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
